cb_op_sequencer: RTL and testbench

//  Command-issuing side of the ALU interface for CB-prefixed opcodes (rotate/shift, BIT, RES, SET).

---
 rtl/cb_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_cb_op_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_op_sequencer.sv
// CB-prefix op sequencer: issues ALU, register write-back and (HL) read-modify-write
// commands for rotate/shift, BIT, RES and SET opcodes, with a memory ack timeout.
module cb_op_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       core_clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] opcode,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] alu_op,
    output logic [2:0] bit_idx,
    output logic [2:0] src_reg,
    output logic       src_mem,
    output logic [7:0] operand_q,
    output logic       alu_out_wr,
    output logic       reg_wr,
    output logic       mem_rd_req,
    output logic       mem_wr_req
);

    typedef enum logic [2:0] {
        StIdle,
        StMrd,
        StExec,
        StRwb,
        StMwr,
        StDone
    } state_e;

    localparam bit         TimeoutEn   = (ACK_TIMEOUT != 0);
    localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [4:0] alu_op_q, alu_op_d;
    logic [7:0] operand_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       src_mem_q, src_mem_d;
    logic [4:0] start_alu_op;
    logic       op_is_hl;
    logic       op_is_bit;
    logic       ack_timeout;

    assign op_is_hl  = (opcode_q[2:0] == 3'b110);
    assign op_is_bit = (opcode_q[7:6] == 2'b01);
    // An ack arriving in the last allowed request cycle still completes the transfer.
    assign ack_timeout = TimeoutEn && !mem_ack && (cnt_q == TimeoutLast);

    always_comb begin
        start_alu_op = 5'b01000;
        unique case (opcode[7:6])
            2'b00: begin
                unique case (opcode[5:3])
                    3'd0: start_alu_op = 5'b10010;
                    3'd1: start_alu_op = 5'b10011;
                    3'd2: start_alu_op = 5'b01001;
                    3'd3: start_alu_op = 5'b10100;
                    3'd4: start_alu_op = 5'b10101;
                    3'd5: start_alu_op = 5'b10110;
                    3'd6: start_alu_op = 5'b01101;
                    3'd7: start_alu_op = 5'b10111;
                endcase
            end
            2'b01: start_alu_op = 5'b01000;
            2'b10: start_alu_op = 5'b01111;
            2'b11: start_alu_op = 5'b10001;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        alu_op_d  = alu_op_q;
        operand_d = operand_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        src_mem_d = src_mem_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opcode_d = opcode;
                    alu_op_d = start_alu_op;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = (opcode[2:0] == 3'b110) ? StMrd : StExec;
                end
            end
            StMrd: begin
                if (mem_ack) begin
                    operand_d = mem_rdata;
                    src_mem_d = 1'b1;
                    state_d   = StExec;
                end else if (ack_timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StExec: begin
                cnt_d = '0;
                if (op_is_bit) begin
                    state_d = StDone;
                end else if (op_is_hl) begin
                    state_d = StMwr;
                end else begin
                    state_d = StRwb;
                end
            end
            StRwb: state_d = StDone;
            StMwr: begin
                if (mem_ack) begin
                    state_d = StDone;
                end else if (ack_timeout) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                src_mem_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            alu_op_q  <= '0;
            operand_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            src_mem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            alu_op_q  <= alu_op_d;
            operand_q <= operand_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            src_mem_q <= src_mem_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign alu_op     = alu_op_q;
    assign bit_idx    = opcode_q[5:3];
    assign src_reg    = opcode_q[2:0];
    assign src_mem    = src_mem_q;
    assign alu_out_wr = (state_q == StExec);
    assign reg_wr     = (state_q == StRwb);
    assign mem_rd_req = (state_q == StMrd);
    assign mem_wr_req = (state_q == StMwr);

endmodule

// File: tb/tb_cb_op_sequencer.sv
// Randomized bench for cb_op_sequencer: a per-op phase model predicts every output each cycle;
// directed scenarios add literal expectations on latency, codes and error behaviour.
module tb_cb_op_sequencer;
    localparam int T = 4;

    logic       core_clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] opcode;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       busy, done, err, src_mem, alu_out_wr, reg_wr, mem_rd_req, mem_wr_req;
    logic [4:0] alu_op;
    logic [2:0] bit_idx, src_reg;
    logic [7:0] operand_q;

    cb_op_sequencer #(.ACK_TIMEOUT(T)) dut (
        .core_clk   (core_clk),
        .reset_n    (reset_n),
        .start      (start),
        .opcode     (opcode),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .alu_op     (alu_op),
        .bit_idx    (bit_idx),
        .src_reg    (src_reg),
        .src_mem    (src_mem),
        .operand_q  (operand_q),
        .alu_out_wr (alu_out_wr),
        .reg_wr     (reg_wr),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req)
    );

    always #5 core_clk = ~core_clk;

    typedef enum int {KIdle, KMrd, KExec, KRwb, KMwr, KDone} phase_e;

    // Expectations, written by the driver only.
    logic       chk_en = 1'b0;
    logic       exp_busy, exp_done, exp_alu, exp_reg, exp_rd, exp_wr, exp_err;
    logic [7:0] exp_operand;
    logic       chk_alu_op, chk_src_mem, exp_src_mem;
    logic [4:0] exp_alu_op;
    logic [2:0] exp_bit, exp_src;

    // Literal checks queued by the driver, drained by the compare process.
    string lit_name [64];
    int    lit_act  [64];
    int    lit_exp  [64];
    int    lit_wr = 0;

    // Compare-process state.
    int         n_vec = 0, n_bad = 0, lit_rd = 0, cyc = 0;
    int         last_alu_cyc = 0, last_reg_cyc = 0, last_done_cyc = 0;
    int         n_alu = 0, n_reg = 0, n_rd = 0, n_wr = 0, n_done = 0;
    logic [4:0] obs_alu_op = '0;
    logic [2:0] obs_bit = '0, obs_src = '0;
    logic       obs_src_mem = 1'b0, obs_err_done = 1'b0;

    // Driver-side model state.
    logic [7:0] cur_op = '0;
    logic       cur_hl = 1'b0, exec_seen = 1'b0, model_err = 1'b0;
    logic [7:0] model_operand = '0;
    int         start_cyc = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge core_clk) begin
        cyc = cyc + 1;
        while (lit_rd < lit_wr) begin
            cmp(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
        if (alu_out_wr) begin
            last_alu_cyc = cyc;
            obs_alu_op   = alu_op;
            obs_bit      = bit_idx;
            obs_src_mem  = src_mem;
            n_alu++;
        end
        if (reg_wr) begin
            last_reg_cyc = cyc;
            obs_src      = src_reg;
            n_reg++;
        end
        if (mem_rd_req) n_rd++;
        if (mem_wr_req) n_wr++;
        if (done) begin
            last_done_cyc = cyc;
            obs_err_done  = err;
            n_done++;
        end
        if (chk_en) begin
            cmp("busy", int'(busy), int'(exp_busy));
            cmp("done", int'(done), int'(exp_done));
            cmp("err", int'(err), int'(exp_err));
            cmp("alu_out_wr", int'(alu_out_wr), int'(exp_alu));
            cmp("reg_wr", int'(reg_wr), int'(exp_reg));
            cmp("mem_rd_req", int'(mem_rd_req), int'(exp_rd));
            cmp("mem_wr_req", int'(mem_wr_req), int'(exp_wr));
            cmp("operand_q", int'(operand_q), int'(exp_operand));
            if (chk_alu_op) cmp("alu_op", int'(alu_op), int'(exp_alu_op));
            if (exp_busy) begin
                cmp("bit_idx", int'(bit_idx), int'(exp_bit));
                cmp("src_reg", int'(src_reg), int'(exp_src));
            end
            if (chk_src_mem) cmp("src_mem", int'(src_mem), int'(exp_src_mem));
        end
    end

    function automatic logic [4:0] alu_code(input logic [7:0] op);
        logic [4:0] shift_tab [8];
        shift_tab = '{5'b10010, 5'b10011, 5'b01001, 5'b10100,
                      5'b10101, 5'b10110, 5'b01101, 5'b10111};
        case (op[7:6])
            2'b00:   return shift_tab[op[5:3]];
            2'b01:   return 5'b01000;
            2'b10:   return 5'b01111;
            default: return 5'b10001;
        endcase
    endfunction

    task automatic lit(input string name, input int act, input int exp);
        lit_name[lit_wr] = name;
        lit_act[lit_wr]  = act;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    task automatic next_cycle();
        @(posedge core_clk);
        #1;
    endtask

    task automatic set_exp(input phase_e k);
        exp_busy    = (k != KIdle);
        exp_done    = (k == KDone);
        exp_alu     = (k == KExec);
        exp_reg     = (k == KRwb);
        exp_rd      = (k == KMrd);
        exp_wr      = (k == KMwr);
        exp_err     = model_err;
        exp_operand = model_operand;
        chk_alu_op  = (k == KExec);
        exp_alu_op  = alu_code(cur_op);
        exp_bit     = cur_op[5:3];
        exp_src     = cur_op[2:0];
        chk_src_mem = exec_seen;
        exp_src_mem = cur_hl;
    endtask

    // Random noise on inputs the DUT must ignore in the current cycle.
    task automatic junk_inputs(input bit allow_start);
        start     = allow_start && ($urandom_range(0, 3) == 0);
        opcode    = 8'($urandom);
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            set_exp(KIdle);
            junk_inputs(1'b0);
        end
    endtask

    // w1/w2: wait cycles before ack on the read/write request; >= T means no ack.
    task automatic run_op(input logic [7:0] op, input int w1, input int w2, input logic [7:0] rdv);
        logic is_bit;
        logic aborted;
        int   n;
        set_exp(KIdle);
        start     = 1'b1;
        opcode    = op;
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
        start_cyc = cyc + 1;
        next_cycle();
        cur_op    = op;
        cur_hl    = (op[2:0] == 3'b110);
        is_bit    = (op[7:6] == 2'b01);
        model_err = 1'b0;
        aborted   = 1'b0;
        if (cur_hl) begin
            n = (w1 < T) ? w1 + 1 : T;
            for (int i = 0; i < n; i++) begin
                set_exp(KMrd);
                junk_inputs(1'b1);
                mem_ack = (i == w1);
                if (i == w1) mem_rdata = rdv;
                next_cycle();
                if (i == w1) model_operand = rdv;
            end
            aborted = (w1 >= T);
        end
        if (!aborted) begin
            exec_seen = 1'b1;
            set_exp(KExec);
            junk_inputs(1'b1);
            next_cycle();
            if (!is_bit && !cur_hl) begin
                set_exp(KRwb);
                junk_inputs(1'b1);
                next_cycle();
            end else if (!is_bit) begin
                n = (w2 < T) ? w2 + 1 : T;
                for (int i = 0; i < n; i++) begin
                    set_exp(KMwr);
                    junk_inputs(1'b1);
                    mem_ack = (i == w2);
                    next_cycle();
                end
                aborted = (w2 >= T);
            end
        end
        if (aborted) model_err = 1'b1;
        set_exp(KDone);
        junk_inputs(1'b1);
        next_cycle();
        exec_seen = 1'b0;
        set_exp(KIdle);
        junk_inputs(1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        logic [26:0] ov;
        int          s0, s1, s2;
        logic [7:0]  op;
        reset_n   = 1'b0;
        start     = 1'b0;
        opcode    = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        set_exp(KIdle);
        next_cycle();
        next_cycle();
        ov = {busy, done, err, alu_op, bit_idx, src_reg, src_mem, operand_q,
              alu_out_wr, reg_wr, mem_rd_req, mem_wr_req};
        lit("reset_state", int'(ov), 0);
        #2 reset_n = 1'b1;
        chk_en = 1'b1;

        // SWAP A
        run_op(8'h37, 0, 0, 8'h00);
        lit("t1_alu_cycle", last_alu_cyc - start_cyc, 1);
        lit("t1_alu_op", int'(obs_alu_op), int'(5'b01101));
        lit("t1_reg_cycle", last_reg_cyc - start_cyc, 2);
        lit("t1_src_reg", int'(obs_src), 7);
        lit("t1_done_cycle", last_done_cyc - start_cyc, 3);
        idle(1);

        // BIT 7,H
        s0 = n_reg;
        run_op(8'h7C, 0, 0, 8'h00);
        lit("t2_alu_cycle", last_alu_cyc - start_cyc, 1);
        lit("t2_alu_op", int'(obs_alu_op), int'(5'b01000));
        lit("t2_bit_idx", int'(obs_bit), 7);
        lit("t2_done_cycle", last_done_cyc - start_cyc, 2);
        lit("t2_no_reg_wr", n_reg - s0, 0);
        idle(2);

        // SET 0,(HL) with two wait cycles on the read
        s0 = n_wr;
        run_op(8'hC6, 2, 0, 8'hA4);
        lit("t3_operand", int'(operand_q), 'hA4);
        lit("t3_src_mem", int'(obs_src_mem), 1);
        lit("t3_alu_op", int'(obs_alu_op), int'(5'b10001));
        lit("t3_wr_cycles", n_wr - s0, 1);
        lit("t3_done_cycle", last_done_cyc - start_cyc, 6);
        idle(1);

        // RES 0,(HL) with the read never acked
        s0 = n_rd;
        s1 = n_alu;
        s2 = n_wr;
        run_op(8'h86, 99, 0, 8'h00);
        lit("t4_rd_cycles", n_rd - s0, 4);
        lit("t4_err_at_done", int'(obs_err_done), 1);
        lit("t4_no_alu_wr", n_alu - s1, 0);
        lit("t4_no_mem_wr", n_wr - s2, 0);
        lit("t4_done_cycle", last_done_cyc - start_cyc, 5);
        run_op(8'h00, 0, 0, 8'h00);
        lit("t4_err_cleared", int'(err), 0);

        // Ack in the final allowed cycle on both requests wins over timeout
        s0 = n_wr;
        run_op(8'hDE, 3, 3, 8'h3C);
        lit("edge_err", int'(err), 0);
        lit("edge_wr_cycles", n_wr - s0, 4);
        lit("edge_done_cycle", last_done_cyc - start_cyc, 10);

        // Write request never acked
        s0 = n_wr;
        run_op(8'h06, 0, 9, 8'h11);
        lit("mwr_timeout_err", int'(obs_err_done), 1);
        lit("mwr_timeout_cycles", n_wr - s0, 4);
        lit("mwr_timeout_done", last_done_cyc - start_cyc, 7);
        idle(1);

        // Reset during MWR, with a stray start while busy
        chk_en  = 1'b0;
        s0      = n_done;
        start   = 1'b1;
        opcode  = 8'hC6;
        mem_ack = 1'b0;
        next_cycle();
        start     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 8'h5A;
        next_cycle();
        start   = 1'b1;
        opcode  = 8'h37;
        mem_ack = 1'b0;
        next_cycle();
        start = 1'b0;
        lit("t5_in_mwr", int'(mem_wr_req), 1);
        lit("t5_stray_ignored", int'(src_reg), 6);
        #2 reset_n = 1'b0;
        #1;
        ov = {busy, done, err, alu_op, bit_idx, src_reg, src_mem, operand_q,
              alu_out_wr, reg_wr, mem_rd_req, mem_wr_req};
        lit("t5_reset_outputs", int'(ov), 0);
        next_cycle();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) next_cycle();
        lit("t5_no_done", n_done - s0, 0);
        lit("t5_idle", int'(busy), 0);
        model_err     = 1'b0;
        model_operand = '0;
        exec_seen     = 1'b0;
        cur_hl        = 1'b0;
        set_exp(KIdle);
        chk_en = 1'b1;
        idle(1);

        for (int k = 0; k < 250; k++) begin
            op = 8'($urandom);
            if ($urandom_range(0, 1) == 1) op[2:0] = 3'b110;
            run_op(op, $urandom_range(0, 5), $urandom_range(0, 5), 8'($urandom));
            idle($urandom_range(0, 2));
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
